bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 WIDTH, 32, data and address bus width in bits.
REQ-002 DEPTH, 16, number of WIDTH-bit storage words; power of two; AW = log2(DEPTH).
REQ-003 BASE_ADDR, 32'h0000_1000, base of the decoded window; aligned to DEPTH*4 bytes.
REQ-004 WAIT_STATES, 2, wait cycles inserted before each transfer; range 0..7.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 ADDR  input  WIDTH  byte address from the initiator.
REQ-008 DATA_IN  input  WIDTH  write data from the initiator.
REQ-009 DATA_OUT  output  WIDTH  read data to the initiator.
REQ-010 rd_  input  1  active-low read strobe.
REQ-011 wr_  input  1  active-low write strobe.
REQ-012 den_  input  1  active-low data enable; gates read-data drive.
REQ-013 stall_  output  1  active-low wait request to the initiator.
REQ-014 data_oe  output  1  high while DATA_OUT is valid and driven.
REQ-015 err  output  1  protocol-error pulse; present only with the macro in REQ-034.

Function
REQ-016 Hit = (ADDR[WIDTH-1:AW+2] == BASE_ADDR[WIDTH-1:AW+2]); word index = ADDR[AW+1:2]; ADDR[1:0] ignored.
REQ-017 FSM states: IDLE, WAIT, XFER, HOLD.
REQ-018 IDLE: on hit with exactly one of rd_/wr_ low, latch index, direction and DATA_IN (write only); go to WAIT with counter = WAIT_STATES-1, or to XFER directly if WAIT_STATES = 0.
REQ-019 IDLE with no hit, or with both strobes high: remain in IDLE; outputs stay at their idle values.
REQ-020 WAIT: stall_ = 0; counter decrements each cycle; go to XFER on the cycle the counter reads 0.
REQ-021 WAIT: if the latched strobe deasserts, abort to IDLE with no storage write and stall_ = 1 on the next cycle.
REQ-022 XFER lasts exactly one cycle with stall_ = 1; a write stores the latched data at the latched index at the end of that cycle.
REQ-023 XFER read: DATA_OUT loads the stored word at the end of XFER; it holds that value through HOLD.
REQ-024 HOLD: data_oe = 1 only when the access is a read and den_ = 0; stay in HOLD until both rd_ and wr_ are high, then go to IDLE.
REQ-025 Leaving HOLD: data_oe = 0 and DATA_OUT is held at its last value.
REQ-026 Latency from strobe sampled low in IDLE to stall_ = 1 with the transfer done is WAIT_STATES+1 cycles.
REQ-027 rd_ and wr_ both low while in IDLE: the access is illegal, no state change occurs, and no storage is modified.
REQ-028 Address changes after the IDLE latch are ignored until the FSM returns to IDLE.
REQ-029 Back-to-back accesses: a new access is accepted only from IDLE, so at least one cycle with both strobes high is required between accesses.

Reset
REQ-030 When rst = 1 at posedge clk: state = IDLE, counter = 0, stall_ = 1, data_oe = 0, DATA_OUT = 0, err = 0, and all storage words = 0.
REQ-031 Reset during WAIT, XFER or HOLD abandons the access, and the write in REQ-022 does not occur on that edge.
REQ-032 Reset takes precedence over every other condition.

Configuration
REQ-033 Without the macro: the err port is absent and illegal accesses (REQ-027) are silently ignored.
REQ-034 With BUS_RESPONDER_ERR_EN defined: the err port exists and pulses high for one cycle for each of these events:
- both strobes low in IDLE on a hit;
- a strobe released during WAIT;
- the opposite strobe asserted during HOLD.

Verification
REQ-035 Reset, then write 32'hDEAD_BEEF to 32'h0000_1008 with WAIT_STATES=2 -> stall_ low for exactly 2 cycles, then word 2 = 32'hDEAD_BEEF.
REQ-036 Read 32'h0000_1008 with den_ = 0 -> after 3 cycles, data_oe = 1 and DATA_OUT = 32'hDEAD_BEEF; data_oe drops the cycle after rd_ rises.
REQ-037 Read 32'h0000_2000 (out of window) -> stall_ stays 1, data_oe stays 0, and no state change occurs.
REQ-038 rd_ and wr_ both low at 32'h0000_1004 -> word 1 unchanged; with BUS_RESPONDER_ERR_EN, err = 1 for one cycle.
REQ-039 Write starts, then wr_ released after 1 WAIT cycle -> FSM returns to IDLE and the target word is unchanged.
REQ-040 rst asserted during HOLD of a read -> next cycle all outputs are at reset values and all storage words read back as 0.

Source files
------------

// File: rtl/bus_responder.sv
// Wait-state bus responder with a DEPTH-word register file behind a decoded address window.
// Optional protocol-error pulse output enabled by defining BUS_RESPONDER_ERR_EN.
module bus_responder #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 16,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h0000_1000,
  parameter int               WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ADDR,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  input  logic             rd_,
  input  logic             wr_,
  input  logic             den_,
  output logic             stall_,
  output logic             data_oe
`ifdef BUS_RESPONDER_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              is_rd_q, is_rd_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_en;
  logic              hit;
  logic              unused_addr_lsb;

  assign hit             = (ADDR[WIDTH-1:AW+2] == BASE_ADDR[WIDTH-1:AW+2]);
  assign unused_addr_lsb = ^ADDR[1:0];

`ifdef BUS_RESPONDER_ERR_EN
  logic err_q, err_d;
  assign err = err_q;
`endif

  // State and datapath registers; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      is_rd_q <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef BUS_RESPONDER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      is_rd_q <= is_rd_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      if (wr_en) mem_q[idx_q] <= wdata_q;
`ifdef BUS_RESPONDER_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    is_rd_d = is_rd_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
`ifdef BUS_RESPONDER_ERR_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        // Exactly one strobe low starts an access; both low is illegal and ignored.
        if (hit && (rd_ ^ wr_)) begin
          idx_d   = ADDR[AW+1:2];
          is_rd_d = ~rd_;
          if (rd_) wdata_d = DATA_IN;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
        end
`ifdef BUS_RESPONDER_ERR_EN
        if (hit && !rd_ && !wr_) err_d = 1'b1;
`endif
      end
      S_WAIT: begin
        if (is_rd_q ? rd_ : wr_) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
`ifdef BUS_RESPONDER_ERR_EN
          err_d   = 1'b1;
`endif
        end else if (cnt_q == 3'd0) begin
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_XFER: begin
        state_d = S_HOLD;
        if (is_rd_q) dout_d = mem_q[idx_q];
        else         wr_en  = 1'b1;
      end
      S_HOLD: begin
        if (rd_ && wr_) state_d = S_IDLE;
`ifdef BUS_RESPONDER_ERR_EN
        if (is_rd_q ? !wr_ : !rd_) err_d = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_   = (state_q != S_WAIT);
    data_oe  = (state_q == S_HOLD) && is_rd_q && !den_;
    DATA_OUT = dout_q;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder (WAIT_STATES = 2); err checks compile in with BUS_RESPONDER_ERR_EN.
module tb_bus_responder;

  logic        clk;
  logic        rst;
  logic [31:0] ADDR;
  logic [31:0] DATA_IN;
  logic [31:0] DATA_OUT;
  logic        rd_, wr_, den_;
  logic        stall_, data_oe;
`ifdef BUS_RESPONDER_ERR_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  bus_responder dut (
    .clk     (clk),
    .rst     (rst),
    .ADDR    (ADDR),
    .DATA_IN (DATA_IN),
    .DATA_OUT(DATA_OUT),
    .rd_     (rd_),
    .wr_     (wr_),
    .den_    (den_),
    .stall_  (stall_),
    .data_oe (data_oe)
`ifdef BUS_RESPONDER_ERR_EN
    ,
    .err     (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    ADDR = a; DATA_IN = d; wr_ = 1'b0;
    cyc(4);
    wr_ = 1'b1;
    cyc(1);
  endtask

  task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ADDR = a; rd_ = 1'b0; den_ = 1'b0;
    cyc(4);
    chk1({tag, "_oe"}, data_oe, 1'b1);
    chkw({tag, "_data"}, DATA_OUT, exp);
    rd_ = 1'b1; den_ = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; ADDR = '0; DATA_IN = '0; rd_ = 1'b1; wr_ = 1'b1; den_ = 1'b1;
    cyc(2);
    chk1("rst_stall", stall_, 1'b1);
    chk1("rst_oe", data_oe, 1'b0);
    chkw("rst_dout", DATA_OUT, 32'h0);
`ifdef BUS_RESPONDER_ERR_EN
    chk1("rst_err", err, 1'b0);
`endif
    rst = 1'b0;
    cyc(1);

    // Write DEADBEEF to word 2; address/data changes after the latch must be ignored.
    ADDR = 32'h0000_1008; DATA_IN = 32'hDEAD_BEEF; wr_ = 1'b0;
    cyc(1);
    chk1("wr_wait1_stall", stall_, 1'b0);
    ADDR = 32'h0000_100C; DATA_IN = 32'h0;
    cyc(1);
    chk1("wr_wait2_stall", stall_, 1'b0);
    cyc(1);
    chk1("wr_xfer_stall", stall_, 1'b1);
    cyc(1);
    chk1("wr_hold_stall", stall_, 1'b1);
    chk1("wr_hold_oe", data_oe, 1'b0);
    wr_ = 1'b1;
    cyc(1);

    // Read word 2 back with full timing.
    ADDR = 32'h0000_1008; rd_ = 1'b0; den_ = 1'b0;
    cyc(1);
    chk1("rd_wait1_stall", stall_, 1'b0);
    chk1("rd_wait1_oe", data_oe, 1'b0);
    cyc(2);
    chk1("rd_xfer_stall", stall_, 1'b1);
    chk1("rd_xfer_oe", data_oe, 1'b0);
    cyc(1);
    chk1("rd_hold_oe", data_oe, 1'b1);
    chkw("rd_hold_data", DATA_OUT, 32'hDEAD_BEEF);
    den_ = 1'b1; #1;
    chk1("rd_hold_den_hi", data_oe, 1'b0);
    den_ = 1'b0; #1;
    chk1("rd_hold_den_lo", data_oe, 1'b1);
`ifdef BUS_RESPONDER_ERR_EN
    wr_ = 1'b0;
    cyc(1);
    chk1("rd_hold_opp_err", err, 1'b1);
    chk1("rd_hold_opp_oe", data_oe, 1'b1);
    wr_ = 1'b1;
    cyc(1);
    chk1("rd_hold_err_clr", err, 1'b0);
`endif
    rd_ = 1'b1; #1;
    chk1("rd_rise_oe_still", data_oe, 1'b1);
    cyc(1);
    chk1("rd_idle_oe", data_oe, 1'b0);
    chkw("rd_idle_dout_held", DATA_OUT, 32'hDEAD_BEEF);
    den_ = 1'b1;

    // Out-of-window read: nothing happens.
    ADDR = 32'h0000_2000; rd_ = 1'b0; den_ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk1("miss_stall", stall_, 1'b1);
      chk1("miss_oe", data_oe, 1'b0);
    end
    chkw("miss_dout", DATA_OUT, 32'hDEAD_BEEF);
    rd_ = 1'b1; den_ = 1'b1;
    cyc(1);

    // Illegal access (both strobes low) leaves word 1 unchanged.
    write_word(32'h0000_1004, 32'h1111_1111);
    ADDR = 32'h0000_1004; DATA_IN = 32'hBAD0_BAD0; rd_ = 1'b0; wr_ = 1'b0;
    cyc(1);
    chk1("ill_stall", stall_, 1'b1);
`ifdef BUS_RESPONDER_ERR_EN
    chk1("ill_err", err, 1'b1);
`endif
    rd_ = 1'b1; wr_ = 1'b1;
    cyc(1);
`ifdef BUS_RESPONDER_ERR_EN
    chk1("ill_err_clr", err, 1'b0);
`endif
    read_word("ill_word1", 32'h0000_1004, 32'h1111_1111);

    // Write aborted during WAIT leaves word 3 unchanged.
    write_word(32'h0000_100C, 32'h1234_5678);
    ADDR = 32'h0000_100C; DATA_IN = 32'hCAFE_F00D; wr_ = 1'b0;
    cyc(1);
    chk1("abort_wait_stall", stall_, 1'b0);
    wr_ = 1'b1;
    cyc(1);
    chk1("abort_idle_stall", stall_, 1'b1);
`ifdef BUS_RESPONDER_ERR_EN
    chk1("abort_err", err, 1'b1);
`endif
    cyc(2);
    chk1("abort_still_idle", stall_, 1'b1);
    read_word("abort_word3", 32'h0000_100C, 32'h1234_5678);
    read_word("word2_again", 32'h0000_1008, 32'hDEAD_BEEF);

    // Reset during HOLD of a read clears outputs and storage.
    ADDR = 32'h0000_1008; rd_ = 1'b0; den_ = 1'b0;
    cyc(4);
    chk1("prerst_oe", data_oe, 1'b1);
    rst = 1'b1;
    cyc(1);
    chk1("hold_rst_stall", stall_, 1'b1);
    chk1("hold_rst_oe", data_oe, 1'b0);
    chkw("hold_rst_dout", DATA_OUT, 32'h0);
    rst = 1'b0; rd_ = 1'b1; den_ = 1'b1;
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      read_word("clr_word", 32'h0000_1000 + 32'(i * 4), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
